hamming_secded_pipe: RTL and testbench
======================================

Name: hamming_secded_pipe

Overview:
- Parametrised, pipelined SECDED Hamming decoder; next generation of the combinational 11-bit Hamming(15,11) corrector.
- Accepts extended Hamming codewords of any data width on a valid/ready stream.
- Corrects single-bit errors and flags double-bit errors.
- Keeps saturating error-statistics counters; sits between the channel/injector and the data consumer.

Parameters:
- DATA_W, 11, data bits per word.
- PAR_W, 4, Hamming parity bits; must satisfy 2**PAR_W >= DATA_W+PAR_W+1 (elaboration error otherwise).
- CNT_W, 8, width of each statistics counter.
- Derived: N = DATA_W+PAR_W; CW = N+1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input codeword valid.
- in_ready  out  1  decoder can accept.
- in_code  in  CW  codeword.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_data  out  DATA_W  corrected data.
- out_status  out  2  00 clean, 01 corrected, 10 uncorrectable, 11 never driven.
- clr_cnt  in  1  synchronous counter clear.
- cnt_corr  out  CNT_W  corrected-word count.
- cnt_unc  out  CNT_W  uncorrectable-word count.

Behaviour:
- Codeword layout:
  - Bit 0 = overall even parity over all CW bits.
  - Bits 1..N = Hamming positions; power-of-two positions are parity bits.
  - Data bits 0..DATA_W-1 fill the remaining positions in ascending order (default: positions 3,5,6,7,9..15).
- Reset (async assert, sync release) drives: stage valids 0, out_valid 0, out_data 0, out_status 00, counters 0. in_ready is 1 after reset.
- Stage 1 registers in_code, syndrome s (PAR_W bits: XOR of positions whose index has each bit set) and overall parity p (XOR of all CW bits).
- Stage 2 registers corrected data and status:
  - s==0, p==0: data unchanged, 00.
  - s==0, p==1: overall bit in error; data unchanged, 01.
  - s!=0, p==1, s<=N: flip position s, extract data, 01.
  - s!=0, p==1, s>N: uncorrectable; raw data extracted, 10.
  - s!=0, p==0: double error; raw data extracted, 10.
- Handshake:
  - adv2 = !v2 | out_ready; adv1 = !v1 | adv2; in_ready = adv1.
  - Transfer occurs when valid & ready.
  - Full throughput: 1 word/cycle.
  - Latency 2 cycles from input handshake to out_valid with no backpressure.
  - out_data and out_status hold stable while out_valid & !out_ready.
  - No word is dropped or duplicated under any backpressure pattern.
- Counters:
  - Update only on an output handshake: status 01 increments cnt_corr, 10 increments cnt_unc.
  - Both counters saturate at all-ones.
  - clr_cnt zeroes both next cycle; clr_cnt concurrent with an increment results in 0 (clear wins).
- Reset mid-operation discards in-flight words.
- in_ready is combinational from out_ready; this is accepted.

Decomposition:
- Package hamming_pkg:
  - Status constants ST_CLEAN=2'b00, ST_CORR=2'b01, ST_UNC=2'b10.
  - Function cw_width(DATA_W,PAR_W).
  - Function is_pow2(pos).
  - Function mapping data index to codeword position.
- Sub-module hamming_syndrome (combinational, parametrised DATA_W/PAR_W): outputs s and p from a codeword. Reused by the future encoder-side checker.

Test Plan:
- Codeword 16'h0000, out_ready=1 -> two cycles later out_data=11'h000, status 00; counters 0.
- 16'hFFFF -> out_data=11'h7FF, status 00. 16'hFFFF^16'h0020 (bit 5 flipped) -> out_data=11'h7FF, status 01, cnt_corr=1.
- 16'h0001 (overall bit only) -> out_data=0, status 01. 16'h0208 (bits 3 and 9) -> status 10, cnt_unc=1.
- Stream 8 words back-to-back with out_ready toggling 1,0,0,1,... -> output order and values identical to a bench reference model; no drop or duplicate; outputs stable during stall.
- Drive 260 single-error words with CNT_W=8 -> cnt_corr=255 and holds. Then pulse clr_cnt coincident with a corrected handshake -> cnt_corr=0.
- Assert rst_n=0 with 2 words in flight -> out_valid=0 and counters 0 immediately (asynchronous). After release, in_ready=1 and the next word decodes normally.

Source files
------------

// File: rtl/hamming_pkg.sv
// hamming_pkg
// Shared definitions for the extended-Hamming (SECDED) decoder family.
//   ST_CLEAN / ST_CORR / ST_UNC : values driven on the 2-bit status output
//   cw_width(data_w, par_w)     : full codeword width including overall parity bit
//   is_pow2(pos)                : true for Hamming positions that hold parity bits
//   data_pos(idx)               : codeword position holding data bit idx
package hamming_pkg;

    localparam logic [1:0] ST_CLEAN = 2'b00;
    localparam logic [1:0] ST_CORR  = 2'b01;
    localparam logic [1:0] ST_UNC   = 2'b10;

    function automatic int cw_width(input int data_w, input int par_w);
        return data_w + par_w + 1;
    endfunction

    function automatic bit is_pow2(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // Data bits fill the non-power-of-two positions in ascending order,
    // so walk the positions and count the ones that are not parity slots.
    function automatic int data_pos(input int idx);
        int pos;
        int seen;
        pos  = 0;
        seen = -1;
        while (seen < idx) begin
            pos++;
            if (!is_pow2(pos)) begin
                seen++;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// hamming_syndrome
// Combinational syndrome / overall-parity generator for an extended Hamming
// codeword. Shared between the decoder pipeline and encoder-side checkers.
//   code : codeword, bit 0 = overall parity, bits 1..N = Hamming positions
//   s    : syndrome, bit b = XOR of all positions whose index has bit b set
//   p    : XOR of every codeword bit (0 for a valid even-parity word)
module hamming_syndrome
    import hamming_pkg::*;
#(
    parameter int DATA_W = 11,
    parameter int PAR_W  = 4
) (
    input  logic [cw_width(DATA_W, PAR_W)-1:0] code,
    output logic [PAR_W-1:0]                   s,
    output logic                               p
);

    localparam int N = DATA_W + PAR_W;

    always_comb begin
        s = '0;
        for (int pos = 1; pos <= N; pos++) begin
            for (int b = 0; b < PAR_W; b++) begin
                if (((pos >> b) & 1) == 1) begin
                    s[b] = s[b] ^ code[pos];
                end
            end
        end
        p = ^code;
    end

endmodule

// File: rtl/hamming_secded_pipe.sv
// hamming_secded_pipe
// Two-stage pipelined SECDED decoder on a valid/ready stream, with saturating
// counters of corrected and uncorrectable words.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : input handshake, in_code = extended Hamming codeword
//   out_valid/out_ready   : output handshake
//   out_data / out_status : corrected data, 00 clean / 01 corrected / 10 uncorrectable
//   clr_cnt               : synchronous clear of both counters (wins over increment)
//   cnt_corr / cnt_unc    : saturating statistics counters
module hamming_secded_pipe
    import hamming_pkg::*;
#(
    parameter int DATA_W = 11,
    parameter int PAR_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [cw_width(DATA_W, PAR_W)-1:0] in_code,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DATA_W-1:0]                  out_data,
    output logic [1:0]                         out_status,
    input  logic                               clr_cnt,
    output logic [CNT_W-1:0]                   cnt_corr,
    output logic [CNT_W-1:0]                   cnt_unc
);

    localparam int N  = DATA_W + PAR_W;
    localparam int CW = N + 1;

    // A syndrome must be able to name every Hamming position plus "no error".
    if ((2 ** PAR_W) < (N + 1)) begin : g_bad_params
        $error("hamming_secded_pipe: PAR_W too small for DATA_W");
    end

    logic [PAR_W-1:0]  syn_s;
    logic              syn_p;
    logic              v1;
    logic [CW-1:0]     code1;
    logic [PAR_W-1:0]  s1;
    logic              p1;
    logic              adv1;
    logic              adv2;
    logic [CW-1:0]     flip;
    logic [CW-1:0]     fixed;
    logic [DATA_W-1:0] dec_data;
    logic [1:0]        dec_status;

    hamming_syndrome #(
        .DATA_W (DATA_W),
        .PAR_W  (PAR_W)
    ) u_syndrome (
        .code (in_code),
        .s    (syn_s),
        .p    (syn_p)
    );

    // Each stage may load when it is empty or its contents leave this cycle.
    assign adv2     = !out_valid || out_ready;
    assign adv1     = !v1 || adv2;
    assign in_ready = adv1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            code1 <= '0;
            s1    <= '0;
            p1    <= 1'b0;
        end else if (adv1) begin
            v1    <= in_valid;
            code1 <= in_code;
            s1    <= syn_s;
            p1    <= syn_p;
        end
    end

    // Odd overall parity means a single error: at the overall bit when the
    // syndrome is zero, otherwise at position s. A syndrome pointing past the
    // last position, or even parity with a nonzero syndrome, is uncorrectable.
    always_comb begin
        flip       = '0;
        dec_status = ST_CLEAN;
        if (s1 == '0) begin
            dec_status = p1 ? ST_CORR : ST_CLEAN;
        end else if (p1 && (int'(s1) <= N)) begin
            flip[s1]   = 1'b1;
            dec_status = ST_CORR;
        end else begin
            dec_status = ST_UNC;
        end
        fixed = code1 ^ flip;
        for (int i = 0; i < DATA_W; i++) begin
            dec_data[i] = fixed[data_pos(i)];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_status <= ST_CLEAN;
        end else if (adv2) begin
            out_valid <= v1;
            if (v1) begin
                out_data   <= dec_data;
                out_status <= dec_status;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_corr <= '0;
            cnt_unc  <= '0;
        end else if (clr_cnt) begin
            cnt_corr <= '0;
            cnt_unc  <= '0;
        end else if (out_valid && out_ready) begin
            if ((out_status == ST_CORR) && (cnt_corr != '1)) begin
                cnt_corr <= cnt_corr + 1'b1;
            end
            if ((out_status == ST_UNC) && (cnt_unc != '1)) begin
                cnt_unc <= cnt_unc + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hamming_secded_pipe.sv
// tb_hamming_secded_pipe
// Directed self-checking bench for hamming_secded_pipe with default
// parameters (11 data bits, 4 parity bits, 16-bit codeword, 8-bit counters).
module tb_hamming_secded_pipe;

    localparam int DATA_W = 11;
    localparam int PAR_W  = 4;
    localparam int CNT_W  = 8;
    localparam int CW     = 16;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              in_valid  = 1'b0;
    logic              in_ready;
    logic [CW-1:0]     in_code   = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_status;
    logic              clr_cnt   = 1'b0;
    logic [CNT_W-1:0]  cnt_corr;
    logic [CNT_W-1:0]  cnt_unc;

    int nTests = 0;
    int nFail  = 0;

    // Stream scenario: data words, injected error masks and the status each
    // one must produce (single errors correct, double errors are flagged).
    logic [DATA_W-1:0] streamData   [8] = '{11'h123, 11'h7FF, 11'h000, 11'h555,
                                            11'h2AA, 11'h0F0, 11'h70F, 11'h3C3};
    logic [CW-1:0]     streamMask   [8] = '{16'h0000, 16'h0020, 16'h0000, 16'h0006,
                                            16'h0001, 16'h0000, 16'h8000, 16'h0101};
    logic [1:0]        streamStatus [8] = '{2'b00, 2'b01, 2'b00, 2'b10,
                                            2'b01, 2'b00, 2'b01, 2'b10};
    bit                readyPat     [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    hamming_secded_pipe #(
        .DATA_W (DATA_W),
        .PAR_W  (PAR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_status (out_status),
        .clr_cnt    (clr_cnt),
        .cnt_corr   (cnt_corr),
        .cnt_unc    (cnt_unc)
    );

    // Free-running clock; all stimulus changes and samples happen at negedge.
    always #5 clk = ~clk;

    // Independent reference encoder: places data bits at the fixed non-parity
    // positions, then fills each parity slot and the overall parity bit.
    function automatic logic [CW-1:0] encode(input logic [DATA_W-1:0] d);
        int            posTab [11];
        logic [CW-1:0] cw;
        logic          par;
        posTab = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
        cw = '0;
        for (int i = 0; i < DATA_W; i++) begin
            cw[posTab[i]] = d[i];
        end
        for (int k = 0; k < PAR_W; k++) begin
            par = 1'b0;
            for (int pos = 1; pos < CW; pos++) begin
                if (((pos >> k) & 1) != 0) begin
                    par = par ^ cw[pos];
                end
            end
            cw[1 << k] = par;
        end
        cw[0] = ^cw[CW-1:1];
        return cw;
    endfunction

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nTests++;
        assert (observed === expected) else begin
            nFail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Offer one codeword until the decoder accepts it (bounded wait).
    // Called and returns at a negedge; the word was taken at the posedge just passed.
    task automatic applyStimulus(input logic [CW-1:0] code);
        bit done;
        done     = 1'b0;
        in_code  = code;
        in_valid = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            done = in_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checkOutput("in_ready_wait", 32'(done), 32'd1);
    endtask

    // Push one word with out_ready high and check the result two edges later.
    task automatic runOne(input logic [CW-1:0] code, input logic [DATA_W-1:0] expData,
                          input logic [1:0] expStatus, input string tag);
        applyStimulus(code);
        @(negedge clk);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_data"}, 32'(out_data), 32'(expData));
        checkOutput({tag, "_status"}, 32'(out_status), 32'(expStatus));
        @(negedge clk);
    endtask

    // Hard stop in case something wedges the stimulus sequence.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed sequence: reset, single vectors, stalled stream, saturation,
    // clear-vs-increment, asynchronous reset with words in flight.
    initial begin
        int            sent;
        int            recv;
        bit            stalled;
        logic [DATA_W-1:0] heldData;
        logic [1:0]    heldStatus;

        repeat (3) @(negedge clk);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_out_status", 32'(out_status), 32'd0);
        checkOutput("rst_cnt_corr", 32'(cnt_corr), 32'd0);
        checkOutput("rst_cnt_unc", 32'(cnt_unc), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        out_ready = 1'b1;
        runOne(16'h0000, 11'h000, 2'b00, "zero");
        checkOutput("zero_cnt_corr", 32'(cnt_corr), 32'd0);
        checkOutput("zero_cnt_unc", 32'(cnt_unc), 32'd0);
        runOne(16'hFFFF, 11'h7FF, 2'b00, "ones");
        runOne(16'hFFFF ^ 16'h0020, 11'h7FF, 2'b01, "bit5");
        checkOutput("bit5_cnt_corr", 32'(cnt_corr), 32'd1);
        runOne(16'h0001, 11'h000, 2'b01, "overall");
        runOne(16'h0208, 11'h011, 2'b10, "double");
        checkOutput("double_cnt_unc", 32'(cnt_unc), 32'd1);
        checkOutput("double_cnt_corr", 32'(cnt_corr), 32'd2);

        // Stream of 8 words while out_ready cycles 1,0,0,1.
        sent    = 0;
        recv    = 0;
        stalled = 1'b0;
        heldData   = '0;
        heldStatus = '0;
        for (int cyc = 0; cyc < 200 && recv < 8; cyc++) begin
            out_ready = readyPat[cyc % 4];
            in_valid  = (sent < 8);
            if (sent < 8) begin
                in_code = encode(streamData[sent]) ^ streamMask[sent];
            end
            #1;
            if (stalled) begin
                checkOutput("stall_valid", 32'(out_valid), 32'd1);
                checkOutput("stall_data", 32'(out_data), 32'(heldData));
                checkOutput("stall_status", 32'(out_status), 32'(heldStatus));
            end
            if (out_valid && out_ready) begin
                checkOutput($sformatf("stream%0d_data", recv), 32'(out_data),
                            32'(streamData[recv]));
                checkOutput($sformatf("stream%0d_status", recv), 32'(out_status),
                            32'(streamStatus[recv]));
                recv++;
            end
            if (in_valid && in_ready) begin
                sent++;
            end
            stalled    = out_valid && !out_ready;
            heldData   = out_data;
            heldStatus = out_status;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        checkOutput("stream_count", 32'(recv), 32'd8);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput("stream_no_dup", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        checkOutput("stream_cnt_corr", 32'(cnt_corr), 32'd5);
        checkOutput("stream_cnt_unc", 32'(cnt_unc), 32'd3);

        // 260 back-to-back corrected words drive cnt_corr into saturation.
        in_code  = 16'hFFDF;
        in_valid = 1'b1;
        repeat (260) @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("sat_cnt_corr", 32'(cnt_corr), 32'd255);
        runOne(16'hFFDF, 11'h7FF, 2'b01, "sat_extra");
        checkOutput("sat_hold_cnt_corr", 32'(cnt_corr), 32'd255);
        checkOutput("sat_cnt_unc", 32'(cnt_unc), 32'd3);

        // Clear pulsed in the same cycle as a corrected-word handshake.
        applyStimulus(16'hFFDF);
        @(negedge clk);
        checkOutput("clr_pending_valid", 32'(out_valid), 32'd1);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        checkOutput("clr_cnt_corr", 32'(cnt_corr), 32'd0);
        checkOutput("clr_cnt_unc", 32'(cnt_unc), 32'd0);
        runOne(16'hFFDF, 11'h7FF, 2'b01, "after_clr");
        checkOutput("after_clr_cnt_corr", 32'(cnt_corr), 32'd1);

        // Two words in flight under backpressure, then asynchronous reset.
        out_ready = 1'b0;
        applyStimulus(16'h0000);
        applyStimulus(16'hFFFF);
        checkOutput("inflight_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_out_valid", 32'(out_valid), 32'd0);
        checkOutput("async_cnt_corr", 32'(cnt_corr), 32'd0);
        checkOutput("async_out_status", 32'(out_status), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_discarded", 32'(out_valid), 32'd0);
        runOne(16'hFFDF, 11'h7FF, 2'b01, "post_rst");

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
